// File: rtl/alu_pkg.sv
// Shared opcode encodings, NZCV bit positions and opcode-class helpers for the execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // TST/TEQ/CMP/CMN: always set flags, never write the register file.
  function automatic logic is_compare(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

  function automatic logic is_logical(input logic [3:0] op);
    return (op inside {OP_AND, OP_EOR, OP_TST, OP_TEQ, OP_ORR, OP_MOV, OP_BIC, OP_MVN});
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ARM data-processing datapath: 33-bit adder plus logic unit, result and N/Z/C/V.
// For logical ops v is driven 0; the caller keeps the old V.
module alu_core
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  input  logic        shift_carry,
  input  logic [3:0]  op,
  output logic [31:0] f,
  output logic        n,
  output logic        z,
  output logic        c,
  output logic        v
);

  logic [31:0] x;
  logic [31:0] y;
  logic        ci;
  logic        use_logic;
  logic [31:0] logic_res;
  logic [32:0] sum;

  // Subtraction is folded into the adder as x + ~y + carry-in.
  always_comb begin
    x  = a;
    y  = b;
    ci = 1'b0;
    case (op)
      OP_SUB, OP_CMP: begin y = ~b; ci = 1'b1; end
      OP_RSB:         begin x = b; y = ~a; ci = 1'b1; end
      OP_ADC:         ci = cin;
      OP_SBC:         begin y = ~b; ci = cin; end
      OP_RSC:         begin x = b; y = ~a; ci = cin; end
      default:        ci = 1'b0;
    endcase
  end

  assign sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};

  always_comb begin
    logic_res = 32'd0;
    case (op)
      OP_AND, OP_TST: logic_res = a & b;
      OP_EOR, OP_TEQ: logic_res = a ^ b;
      OP_ORR:         logic_res = a | b;
      OP_MOV:         logic_res = b;
      OP_BIC:         logic_res = a & ~b;
      OP_MVN:         logic_res = ~b;
      default:        logic_res = 32'd0;
    endcase
  end

  assign use_logic = is_logical(op);
  assign f = use_logic ? logic_res : sum[31:0];
  assign n = f[31];
  assign z = (f == 32'd0);
  assign c = use_logic ? shift_carry : sum[32];
  assign v = use_logic ? 1'b0 : ((x[31] == y[31]) && (sum[31] != x[31]));

endmodule

// File: rtl/alu_execute_stage.sv
// Execute-stage ALU with NZCV register and a registered valid/ready output; flags update at accept.
// ALU_SKID_EN adds a one-entry skid buffer so In_ready becomes a register output.
module alu_execute_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        In_valid,
  output logic        In_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Shift_carry,
  input  logic [3:0]  ALU_OP,
  input  logic        S,
  output logic        Out_valid,
  input  logic        Out_ready,
  output logic [31:0] F,
  output logic        Wr_en,
  output logic [3:0]  NZCV,
  output logic        Carry_flag
);

  logic [31:0] core_f;
  logic        core_n, core_z, core_c, core_v;
  logic        accept, pop, new_wr;

  logic        out_valid_q, out_valid_d;
  logic [31:0] f_q, f_d;
  logic        wr_en_q, wr_en_d;
  logic [3:0]  nzcv_q, nzcv_d;

  alu_core u_core (
    .a           (A),
    .b           (B),
    .cin         (nzcv_q[FLAG_C]),
    .shift_carry (Shift_carry),
    .op          (ALU_OP),
    .f           (core_f),
    .n           (core_n),
    .z           (core_z),
    .c           (core_c),
    .v           (core_v)
  );

  assign accept = In_valid && In_ready;
  assign pop    = out_valid_q && Out_ready;
  assign new_wr = !is_compare(ALU_OP);

  always_comb begin
    nzcv_d = nzcv_q;
    if (accept && (S || is_compare(ALU_OP))) begin
      nzcv_d[FLAG_N] = core_n;
      nzcv_d[FLAG_Z] = core_z;
      nzcv_d[FLAG_C] = core_c;
      nzcv_d[FLAG_V] = is_logical(ALU_OP) ? nzcv_q[FLAG_V] : core_v;
    end
  end

`ifdef ALU_SKID_EN
  logic        skid_full_q, skid_full_d;
  logic [31:0] skid_f_q, skid_f_d;
  logic        skid_wr_q, skid_wr_d;
  logic        in_ready_q, in_ready_d;

  assign In_ready = in_ready_q && !rst;

  // Output slot frees when empty or draining; the skid entry always moves ahead of a new op.
  always_comb begin
    out_valid_d = out_valid_q;
    f_d         = f_q;
    wr_en_d     = wr_en_q;
    skid_full_d = skid_full_q;
    skid_f_d    = skid_f_q;
    skid_wr_d   = skid_wr_q;
    if (!out_valid_q || pop) begin
      if (skid_full_q) begin
        out_valid_d = 1'b1;
        f_d         = skid_f_q;
        wr_en_d     = skid_wr_q;
        skid_full_d = accept;
        if (accept) begin
          skid_f_d  = core_f;
          skid_wr_d = new_wr;
        end
      end else begin
        out_valid_d = accept;
        if (accept) begin
          f_d     = core_f;
          wr_en_d = new_wr;
        end
      end
    end else if (accept) begin
      skid_full_d = 1'b1;
      skid_f_d    = core_f;
      skid_wr_d   = new_wr;
    end
    in_ready_d = !skid_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_full_q <= 1'b0;
      skid_f_q    <= 32'd0;
      skid_wr_q   <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      skid_full_q <= skid_full_d;
      skid_f_q    <= skid_f_d;
      skid_wr_q   <= skid_wr_d;
      in_ready_q  <= in_ready_d;
    end
  end
`else
  assign In_ready = !rst && (!out_valid_q || Out_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    f_d         = f_q;
    wr_en_d     = wr_en_q;
    if (accept) begin
      out_valid_d = 1'b1;
      f_d         = core_f;
      wr_en_d     = new_wr;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      f_q         <= 32'd0;
      wr_en_q     <= 1'b0;
      nzcv_q      <= 4'd0;
    end else begin
      out_valid_q <= out_valid_d;
      f_q         <= f_d;
      wr_en_q     <= wr_en_d;
      nzcv_q      <= nzcv_d;
    end
  end

  assign Out_valid  = out_valid_q;
  assign F          = f_q;
  assign Wr_en      = wr_en_q;
  assign NZCV       = nzcv_q;
  assign Carry_flag = nzcv_q[FLAG_C];

endmodule
